// File: rtl/span_fill_engine.sv
// Scanline span fill engine: walks mask rows, derives hull or even-odd spans and
// paints them into a layer buffer row with read-modify-write over a ready handshake.
module span_fill_engine #(
    parameter int PIX_BITS   = 24,
    parameter int ROW_PIXELS = 64,
    parameter int NUM_ROWS   = 64,
    parameter int FB_STRIDE  = 256,
    parameter int NUM_LAYERS = 4,
    parameter int LAYER_STEP = 65536,
    parameter int ADDR_BITS  = 24
) (
    input  logic                             clk,
    input  logic                             n_rst,
    input  logic                             start,
    input  logic                             abort,
    input  logic                             mode,
    input  logic [$clog2(NUM_LAYERS)-1:0]    layer_sel,
    input  logic [7:0]                       origin_x,
    input  logic [7:0]                       origin_y,
    input  logic [PIX_BITS-1:0]              color,
    output logic [$clog2(NUM_ROWS)-1:0]      mask_row_idx,
    input  logic [ROW_PIXELS-1:0]            mask_row,
    output logic [ADDR_BITS-1:0]             mem_addr,
    output logic                             mem_re,
    output logic                             mem_we,
    input  logic                             mem_ready,
    input  logic [PIX_BITS*ROW_PIXELS-1:0]   mem_rdata,
    output logic [PIX_BITS*ROW_PIXELS-1:0]   mem_wdata,
    output logic                             busy,
    output logic                             done,
    output logic [$clog2(NUM_ROWS+1)-1:0]    rows_written
);

    localparam int LAYER_W = $clog2(NUM_LAYERS);
    localparam int IDX_W   = $clog2(NUM_ROWS);
    localparam int CNT_W   = $clog2(NUM_ROWS+1);
    localparam int WORD_W  = PIX_BITS*ROW_PIXELS;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_MASK, S_SCAN, S_READ, S_WRITE, S_NEXT, S_DONE
    } state_t;

    state_t state, state_nx;

    logic                  mode_q;
    logic [LAYER_W-1:0]    layer_q;
    logic [7:0]            ox_q;
    logic [7:0]            oy_q;
    logic [PIX_BITS-1:0]   color_q;
    logic [CNT_W-1:0]      row;
    logic [ADDR_BITS-1:0]  row_addr;
    logic [ADDR_BITS-1:0]  base_addr;
    logic [ROW_PIXELS-1:0] mask_q;
    logic [ROW_PIXELS-1:0] fill_q;
    logic [WORD_W-1:0]     wdata_q;
    logic                  abort_pend;

    logic [ROW_PIXELS-1:0] pre_or;
    logic [ROW_PIXELS-1:0] suf_or;
    logic [ROW_PIXELS-1:0] pre_par;
    logic [ROW_PIXELS-1:0] fill_hull;
    logic [ROW_PIXELS-1:0] fill_eo;
    logic                  seen;
    logic                  par;
    logic [WORD_W-1:0]     merged;
    logic                  last_row;

    assign base_addr = ADDR_BITS'(layer_q) * ADDR_BITS'(LAYER_STEP)
                     + ADDR_BITS'(oy_q) * ADDR_BITS'(FB_STRIDE)
                     + ADDR_BITS'(ox_q);

    assign mask_row_idx = row[IDX_W-1:0];
    assign mem_addr     = row_addr;
    assign mem_wdata    = wdata_q;
    assign last_row     = (row == CNT_W'(NUM_ROWS - 1));

    // Hull = bits with a set bit at or below AND at or above; even-odd paints where
    // the parity of bits strictly below is odd and a closing bit exists above.
    always_comb begin
        pre_or  = '0;
        suf_or  = '0;
        pre_par = '0;
        seen    = 1'b0;
        par     = 1'b0;
        for (int unsigned i = 0; i < ROW_PIXELS; i++) begin
            pre_par[i] = par;
            par        = par ^ mask_q[i];
            seen       = seen | mask_q[i];
            pre_or[i]  = seen;
        end
        seen = 1'b0;
        for (int unsigned i = ROW_PIXELS; i > 0; i--) begin
            seen        = seen | mask_q[i-1];
            suf_or[i-1] = seen;
        end
        fill_hull = pre_or & suf_or;
        fill_eo   = mask_q | (pre_par & (suf_or >> 1));
    end

    always_comb begin
        merged = '0;
        for (int unsigned p = 0; p < ROW_PIXELS; p++) begin
            merged[p*PIX_BITS +: PIX_BITS] = fill_q[p] ? color_q
                                                       : mem_rdata[p*PIX_BITS +: PIX_BITS];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        mem_re   = 1'b0;
        mem_we   = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nx = S_LOAD;
            end
            S_LOAD:  state_nx = abort ? S_IDLE : S_MASK;
            S_MASK:  state_nx = abort ? S_IDLE : S_SCAN;
            S_SCAN: begin
                if (abort)          state_nx = S_IDLE;
                else if (mask_q == '0) state_nx = S_NEXT;
                else                state_nx = S_READ;
            end
            S_READ: begin
                mem_re = 1'b1;
                if (mem_ready) state_nx = S_WRITE;
            end
            S_WRITE: begin
                mem_we = 1'b1;
                if (mem_ready) state_nx = S_NEXT;
            end
            S_NEXT: begin
                if (abort || abort_pend) state_nx = S_IDLE;
                else if (last_row)       state_nx = S_DONE;
                else                     state_nx = S_MASK;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mode_q       <= 1'b0;
            layer_q      <= '0;
            ox_q         <= '0;
            oy_q         <= '0;
            color_q      <= '0;
            row          <= '0;
            row_addr     <= '0;
            mask_q       <= '0;
            fill_q       <= '0;
            wdata_q      <= '0;
            abort_pend   <= 1'b0;
            rows_written <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_q  <= mode;
                        layer_q <= layer_sel;
                        ox_q    <= origin_x;
                        oy_q    <= origin_y;
                        color_q <= color;
                    end
                end
                S_LOAD: begin
                    row          <= '0;
                    row_addr     <= base_addr;
                    rows_written <= '0;
                    abort_pend   <= 1'b0;
                end
                S_MASK: mask_q <= mask_row;
                S_SCAN: fill_q <= mode_q ? fill_eo : fill_hull;
                S_READ: begin
                    if (abort)     abort_pend <= 1'b1;
                    if (mem_ready) wdata_q    <= merged;
                end
                S_WRITE: begin
                    if (abort)     abort_pend   <= 1'b1;
                    if (mem_ready) rows_written <= rows_written + CNT_W'(1);
                end
                S_NEXT: begin
                    row      <= row + CNT_W'(1);
                    row_addr <= row_addr + ADDR_BITS'(FB_STRIDE);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_span_fill_engine.sv
// Randomised bench for span_fill_engine with a behavioural fill/address model and
// a memory responder providing address-derived read data and configurable ready stalls.
module tb_span_fill_engine;

    localparam int PB    = 24;
    localparam int RP    = 64;
    localparam int NR    = 64;
    localparam int STR   = 256;
    localparam int LSTEP = 65536;
    localparam int WW    = PB*RP;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          start, abort, mode;
    logic [1:0]    layer_sel;
    logic [7:0]    origin_x, origin_y;
    logic [23:0]   color;
    logic [5:0]    mask_row_idx;
    logic [63:0]   mask_row;
    logic [23:0]   mem_addr;
    logic          mem_re, mem_we, mem_ready;
    logic [WW-1:0] mem_rdata, mem_wdata;
    logic          busy, done;
    logic [6:0]    rows_written;

    span_fill_engine #(
        .PIX_BITS(PB), .ROW_PIXELS(RP), .NUM_ROWS(NR), .FB_STRIDE(STR),
        .NUM_LAYERS(4), .LAYER_STEP(LSTEP), .ADDR_BITS(24)
    ) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .abort(abort), .mode(mode),
        .layer_sel(layer_sel), .origin_x(origin_x), .origin_y(origin_y), .color(color),
        .mask_row_idx(mask_row_idx), .mask_row(mask_row), .mem_addr(mem_addr),
        .mem_re(mem_re), .mem_we(mem_we), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .rows_written(rows_written)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0]   addr;
        logic [WW-1:0] data;
    } wr_t;

    logic [63:0] mask_mem [NR];
    logic [31:0] salt = 32'h1234_5678;
    wr_t         wq[$];
    int          reads, act_cyc, dones, overlap, unstable;
    int          stall_n = 0;
    int          ready_pct = 100;
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic [23:0] gen_pix(logic [23:0] a, int p, logic [31:0] s);
        logic [31:0] v;
        v = {8'h00, a} * 32'h0000_9E37 + 32'(p) * 32'h0003_C6EF + s;
        v = v ^ (v >> 13);
        return v[23:0];
    endfunction

    function automatic logic [WW-1:0] gen_row(logic [23:0] a, logic [31:0] s);
        logic [WW-1:0] r;
        r = '0;
        for (int p = 0; p < RP; p++) r[p*PB +: PB] = gen_pix(a, p, s);
        return r;
    endfunction

    assign mask_row  = mask_mem[mask_row_idx];
    assign mem_rdata = gen_row(mem_addr, salt);

    // Reference fill: hull spans lowest..highest set bit; even-odd paints set bits and
    // pixels with an odd count of set bits below and at least one set bit above.
    function automatic logic [63:0] model_fill(logic [63:0] m, logic md);
        logic [63:0] f;
        int lo, hi, cnt;
        logic above;
        f  = '0;
        lo = -1;
        hi = -1;
        if (m == 64'd0) return f;
        if (!md) begin
            for (int p = 0; p < RP; p++) if (m[p]) begin
                if (lo < 0) lo = p;
                hi = p;
            end
            for (int p = lo; p <= hi; p++) f[p] = 1'b1;
        end else begin
            for (int p = 0; p < RP; p++) begin
                cnt = 0;
                above = 1'b0;
                for (int q = 0; q < p; q++) cnt += int'(m[q]);
                for (int q = p + 1; q < RP; q++) above |= m[q];
                f[p] = m[p] | ((cnt % 2 == 1) && above);
            end
        end
        return f;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin : ready_driver
        int wait_cnt;
        wait_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_n >= 0) begin
                if (mem_ready) wait_cnt = 0;
                if (mem_re || mem_we) begin
                    if (wait_cnt < stall_n) begin
                        mem_ready = 1'b0;
                        wait_cnt++;
                    end else mem_ready = 1'b1;
                end else begin
                    mem_ready = 1'b0;
                    wait_cnt  = 0;
                end
            end else begin
                mem_ready = (int'($urandom_range(99)) < ready_pct);
            end
        end
    end

    initial begin : monitor
        logic          re_wait, we_wait;
        logic [23:0]   p_addr;
        logic [WW-1:0] p_wdata;
        re_wait = 1'b0;
        we_wait = 1'b0;
        p_addr  = '0;
        p_wdata = '0;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                re_wait = 1'b0;
                we_wait = 1'b0;
            end else begin
                if (mem_re && mem_we) overlap++;
                if (mem_re || mem_we) act_cyc++;
                if (re_wait && (!mem_re || mem_addr != p_addr)) unstable++;
                if (we_wait && (!mem_we || mem_addr != p_addr || mem_wdata != p_wdata)) unstable++;
                if (mem_re && mem_ready) reads++;
                if (mem_we && mem_ready) wq.push_back('{addr: mem_addr, data: mem_wdata});
                if (done) dones++;
                re_wait = mem_re && !mem_ready;
                we_wait = mem_we && !mem_ready;
                p_addr  = mem_addr;
                p_wdata = mem_wdata;
            end
        end
    end

    task automatic rand_masks();
        for (int r = 0; r < NR; r++) begin
            case ($urandom_range(3))
                0: mask_mem[r] = '0;
                1: mask_mem[r] = 64'd1 << $urandom_range(63);
                default: mask_mem[r] = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            endcase
        end
    endtask

    task automatic run_job(input logic md, input logic [1:0] ly, input logic [7:0] ox,
                           input logic [7:0] oy, input logic [23:0] col, input int stall,
                           input int pct, input int abort_n, input string nm);
        int act_rows[$];
        int n_exp, cyc, done_cyc, rd_seen, bad, r;
        logic prev_re, aborted;
        logic [23:0] ea;
        logic [63:0] f;
        logic [23:0] ep;

        for (int i = 0; i < NR; i++) if (mask_mem[i] != 64'd0) act_rows.push_back(i);
        n_exp = (abort_n > 0) ? abort_n : act_rows.size();

        @(negedge clk);
        wq.delete();
        reads = 0; act_cyc = 0; dones = 0; overlap = 0; unstable = 0;
        salt = $urandom;
        stall_n = stall;
        ready_pct = pct;
        mode = md; layer_sel = ly; origin_x = ox; origin_y = oy; color = col;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        mode = ~md; layer_sel = 2'($urandom); origin_x = 8'($urandom);
        origin_y = 8'($urandom); color = 24'($urandom);

        cyc = 0; done_cyc = -1; rd_seen = 0; prev_re = 1'b0; aborted = 1'b0;
        while (cyc < 20000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (abort) abort = 1'b0;
            if (cyc == 3) start = 1'b1;
            if (cyc == 4) start = 1'b0;
            if (done && done_cyc < 0) done_cyc = cyc;
            if (mem_re && !prev_re) rd_seen++;
            prev_re = mem_re;
            if (abort_n > 0 && !aborted && mem_re && rd_seen == abort_n) begin
                abort   = 1'b1;
                aborted = 1'b1;
            end
            if (!busy) break;
        end
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);

        chk({nm, ":busy_end"}, 64'(busy), 64'd0);
        chk({nm, ":n_writes"}, 64'(wq.size()), 64'(n_exp));
        for (int i = 0; i < wq.size() && i < n_exp; i++) begin
            r  = act_rows[i];
            ea = 24'(int'(ly) * LSTEP + int'(oy) * STR + int'(ox) + r * STR);
            f  = model_fill(mask_mem[r], md);
            bad = 0;
            for (int p = 0; p < RP; p++) begin
                ep = f[p] ? col : gen_pix(ea, p, salt);
                if (wq[i].data[p*PB +: PB] != ep) bad++;
            end
            chk($sformatf("%s:addr_r%0d", nm, r), 64'(wq[i].addr), 64'(ea));
            chk($sformatf("%s:badpix_r%0d", nm, r), 64'(bad), 64'd0);
        end
        chk({nm, ":rows_written"}, 64'(rows_written), 64'(n_exp));
        chk({nm, ":reads"}, 64'(reads), 64'(n_exp));
        chk({nm, ":done_pulses"}, 64'(dones), (abort_n > 0) ? 64'd0 : 64'd1);
        chk({nm, ":re_we_overlap"}, 64'(overlap), 64'd0);
        chk({nm, ":unstable"}, 64'(unstable), 64'd0);
        if (abort_n == 0 && stall >= 0)
            chk({nm, ":done_cycle"}, 64'(done_cyc),
                64'(1 + 3*NR + (2 + 2*stall) * act_rows.size()));
    endtask

    initial begin : main
        int k;
        n_rst = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0; layer_sel = '0;
        origin_x = '0; origin_y = '0; color = '0; mem_ready = 1'b0;
        for (int r = 0; r < NR; r++) mask_mem[r] = '0;
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_re", 64'(mem_re), 64'd0);
        chk("rst_we", 64'(mem_we), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_rows", 64'(rows_written), 64'd0);
        chk("rst_idx", 64'(mask_row_idx), 64'd0);
        chk("rst_wdata_or", 64'(|mem_wdata), 64'd0);
        @(negedge clk);
        n_rst = 1'b1;

        mask_mem[0] = (64'd1 << 3) | (64'd1 << 9);
        run_job(1'b0, 2'd1, 8'd10, 8'd5, 24'hA5C3E1, 0, 100, 0, "hull_spec");
        if (wq.size() > 0) chk("hull_spec:addr_1050A", 64'(wq[0].addr), 64'h1050A);

        rand_masks();
        mask_mem[7] = (64'd1 << 2) | (64'd1 << 5) | (64'd1 << 10) | (64'd1 << 14) | (64'd1 << 20);
        run_job(1'b1, 2'($urandom), 8'($urandom), 8'($urandom), 24'($urandom), 0, 100, 0, "eo_spec");

        for (int r = 0; r < NR; r++) mask_mem[r] = '0;
        run_job(1'b0, 2'd2, 8'd3, 8'd4, 24'h123456, 0, 100, 0, "empty");
        chk("empty:mem_activity", 64'(act_cyc), 64'd0);

        rand_masks();
        mask_mem[1] = 64'h0000_0F00_0010_0000;
        mask_mem[4] = 64'h8000_0000_0000_0001;
        run_job(1'b0, 2'd2, 8'd40, 8'd17, 24'h00FF00, 5, 100, 2, "stall_abort");

        for (int r = 0; r < NR; r++) mask_mem[r] = '0;
        mask_mem[63] = 64'h00F0_0000_0000_0100;
        run_job(1'b1, 2'd3, 8'd255, 8'd255, 24'hFEDCBA, 0, 100, 0, "corner");
        if (wq.size() > 0) chk("corner:addr_abs", 64'(wq[0].addr), 64'd278271);

        for (int j = 0; j < 6; j++) begin
            rand_masks();
            k = (j == 5) ? 2 : -1;
            run_job(1'($urandom), 2'($urandom), 8'($urandom), 8'($urandom), 24'($urandom),
                    k, int'($urandom_range(30, 100)), 0, $sformatf("rand%0d", j));
        end

        rand_masks();
        mask_mem[0] = 64'h0000_0000_00FF_0000;
        stall_n = 5;
        @(negedge clk);
        mode = 1'b0; layer_sel = 2'd0; origin_x = 8'd1; origin_y = 8'd1; color = 24'h0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 100 && !mem_re; i++) begin
            @(posedge clk);
            #1;
        end
        chk("rstmid:saw_re", 64'(mem_re), 64'd1);
        #2;
        n_rst = 1'b0;
        #1;
        chk("rstmid:re", 64'(mem_re), 64'd0);
        chk("rstmid:busy", 64'(busy), 64'd0);
        chk("rstmid:addr", 64'(mem_addr), 64'd0);
        @(negedge clk);
        n_rst = 1'b1;

        rand_masks();
        run_job(1'b1, 2'd1, 8'd77, 8'd200, 24'h0F0F0F, 1, 100, 0, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
